// File: rtl/mem_bus_arbiter_if.sv
// Native memory bus (valid/ready/addr/wdata/wstrb/rdata) as seen by one link.
// The master side raises valid with a request; the slave side answers with
// ready and rdata.
interface mem_bus_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of one native-memory-bus slave.
// One transaction in flight, every bus-facing output registered, and a
// watchdog that answers a hung slave with ERR_DATA and a sticky error flag.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned TO_W     = 9,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              nrst,
  mem_bus_arbiter_if.slave  m0,
  mem_bus_arbiter_if.slave  m1,
  mem_bus_arbiter_if.master s,
  output logic              owner,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A TIMEOUT of zero switches the watchdog off entirely.
  localparam bit              WD_EN    = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] CNT_LAST = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state_q, state_d;
  logic            prio_q;
  logic            owner_q;
  logic [TO_W-1:0] cnt_q;
  logic            s_valid_q;
  logic [31:0]     s_addr_q;
  logic [31:0]     s_wdata_q;
  logic [3:0]      s_wstrb_q;
  logic            m0_ready_q, m1_ready_q;
  logic [31:0]     m0_rdata_q, m1_rdata_q;
  logic            err_q;

  logic            grant;
  logic            grant_sel;
  logic            finish;
  logic            expire;
  logic [31:0]     resp_data;

  assign s.valid     = s_valid_q;
  assign s.addr      = s_addr_q;
  assign s.wdata     = s_wdata_q;
  assign s.wstrb     = s_wstrb_q;
  assign m0.ready    = m0_ready_q;
  assign m0.rdata    = m0_rdata_q;
  assign m1.ready    = m1_ready_q;
  assign m1.rdata    = m1_rdata_q;
  assign owner       = owner_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;
  assign resp_data   = expire ? ERR_DATA : s.rdata;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the grant / completion strobes that drive the datapath.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_sel = 1'b0;
    finish    = 1'b0;
    expire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          grant     = 1'b1;
          // On a tie the favoured master wins; otherwise whoever is asking.
          grant_sel = (m0.valid && m1.valid) ? prio_q : m1.valid;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s.ready) begin
          finish  = 1'b1;
          state_d = DONE;
        end else if (WD_EN && (cnt_q == CNT_LAST)) begin
          finish  = 1'b1;
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      // No arbitration here: the finished master is still dropping its valid.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request side: capture the granted request, hold it until completion, run the watchdog.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      s_valid_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
    end else if (grant) begin
      prio_q    <= ~grant_sel;
      owner_q   <= grant_sel;
      cnt_q     <= '0;
      s_valid_q <= 1'b1;
      s_addr_q  <= grant_sel ? m1.addr  : m0.addr;
      s_wdata_q <= grant_sel ? m1.wdata : m0.wdata;
      s_wstrb_q <= grant_sel ? m1.wstrb : m0.wstrb;
    end else if (finish) begin
      s_valid_q <= 1'b0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  // Response side: one-cycle ready pulse to the owner, rdata held afterwards.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m0_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_ready_q <= 1'b0;
      m1_rdata_q <= '0;
    end else if (finish) begin
      if (owner_q) begin
        m1_ready_q <= 1'b1;
        m1_rdata_q <= resp_data;
      end else begin
        m0_ready_q <= 1'b1;
        m0_rdata_q <= resp_data;
      end
    end else if (state_q == DONE) begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
    end
  end

  // Sticky watchdog flag; an expiry beats a clear in the same cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        err_q <= 1'b0;
    else if (expire)  err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single read, tie alternation, write
// capture, watchdog, reset mid-transaction and a randomised model comparison.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic err_clr = 1'b0;
  logic owner, busy, err_timeout;
  int   checks = 0;
  int   errors = 0;

  mem_bus_arbiter_if m0_bus ();
  mem_bus_arbiter_if m1_bus ();
  mem_bus_arbiter_if s_bus ();

  mem_bus_arbiter #(
    .TIMEOUT  (16),
    .TO_W     (5),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .s           (s_bus),
    .owner       (owner),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_time_limit got no finish want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
    m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
    s_bus.ready  = 1'b0; s_bus.rdata = '0;
    err_clr      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #1 nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic wait_svalid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (s_bus.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Slave answers lat cycles after the current one, then drops ready.
  task automatic slave_respond(input int lat, input logic [31:0] data);
    repeat (lat) tick();
    s_bus.ready = 1'b1;
    s_bus.rdata = data;
    tick();
    s_bus.ready = 1'b0;
    s_bus.rdata = 32'hBAD0BAD0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 nrst = 1'b0;
    #1;
    checks++; if (s_bus.valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid got %0h want 0", s_bus.valid); end
    checks++; if (s_bus.addr !== 32'h0) begin errors++; $display("FAIL rst_s_addr got %0h want 0", s_bus.addr); end
    checks++; if (s_bus.wdata !== 32'h0) begin errors++; $display("FAIL rst_s_wdata got %0h want 0", s_bus.wdata); end
    checks++; if (s_bus.wstrb !== 4'h0) begin errors++; $display("FAIL rst_s_wstrb got %0h want 0", s_bus.wstrb); end
    checks++; if ({m0_bus.ready, m1_bus.ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", {m0_bus.ready, m1_bus.ready}); end
    checks++; if (m0_bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rdata got %0h want 0", m0_bus.rdata); end
    checks++; if (m1_bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_m1_rdata got %0h want 0", m1_bus.rdata); end
    checks++; if ({owner, busy, err_timeout} !== 3'b000) begin errors++; $display("FAIL rst_status got %b want 000", {owner, busy, err_timeout}); end
    tick();
    nrst = 1'b1;
    tick();
    checks++; if ({busy, s_bus.valid} !== 2'b00) begin errors++; $display("FAIL rst_idle got %b want 00", {busy, s_bus.valid}); end
  endtask

  task automatic test_single_read();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h100; m0_bus.wdata = 32'h0; m0_bus.wstrb = 4'h0;
    tick(); // cycle 1
    checks++; if (s_bus.valid !== 1'b1) begin errors++; $display("FAIL rd_s_valid got %0h want 1", s_bus.valid); end
    checks++; if (s_bus.addr !== 32'h100) begin errors++; $display("FAIL rd_s_addr got %0h want 100", s_bus.addr); end
    checks++; if (s_bus.wstrb !== 4'h0) begin errors++; $display("FAIL rd_s_wstrb got %0h want 0", s_bus.wstrb); end
    checks++; if ({owner, busy} !== 2'b01) begin errors++; $display("FAIL rd_owner_busy got %b want 01", {owner, busy}); end
    tick(); // cycle 2
    s_bus.ready = 1'b1; s_bus.rdata = 32'h12345678;
    checks++; if (m0_bus.ready !== 1'b0) begin errors++; $display("FAIL rd_early_ready got %0h want 0", m0_bus.ready); end
    tick(); // cycle 3
    s_bus.ready = 1'b0; s_bus.rdata = 32'hBAD0BAD0;
    checks++; if (m0_bus.ready !== 1'b1) begin errors++; $display("FAIL rd_m0_ready got %0h want 1", m0_bus.ready); end
    checks++; if (m0_bus.rdata !== 32'h12345678) begin errors++; $display("FAIL rd_m0_rdata got %0h want 12345678", m0_bus.rdata); end
    checks++; if ({m1_bus.ready, s_bus.valid} !== 2'b00) begin errors++; $display("FAIL rd_m1_ready_svalid got %b want 00", {m1_bus.ready, s_bus.valid}); end
    checks++; if (m1_bus.rdata !== 32'h0) begin errors++; $display("FAIL rd_m1_rdata got %0h want 0", m1_bus.rdata); end
    m0_bus.valid = 1'b0;
    tick(); // cycle 4
    checks++; if ({m0_bus.ready, busy} !== 2'b00) begin errors++; $display("FAIL rd_after got %b want 00", {m0_bus.ready, busy}); end
    checks++; if (m0_bus.rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata_hold got %0h want 12345678", m0_bus.rdata); end
  endtask

  task automatic test_alternate();
    bit ok;
    logic exp_owner;
    logic [31:0] d;
    do_reset();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h1000; m0_bus.wstrb = 4'h0;
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h2000; m1_bus.wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      exp_owner = (i % 2 == 1);
      d = 32'hA0000000 + i;
      wait_svalid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL alt_grant_wait[%0d] got no s_valid want s_valid", i); end
      checks++; if (owner !== exp_owner) begin errors++; $display("FAIL alt_owner[%0d] got %0h want %0h", i, owner, exp_owner); end
      checks++; if (s_bus.addr !== (exp_owner ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL alt_s_addr[%0d] got %0h want %0h", i, s_bus.addr, exp_owner ? 32'h2000 : 32'h1000); end
      slave_respond(1, d);
      checks++; if ({m1_bus.ready, m0_bus.ready} !== (exp_owner ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_ready[%0d] got %b want %b", i, {m1_bus.ready, m0_bus.ready}, exp_owner ? 2'b10 : 2'b01); end
      checks++; if ((exp_owner ? m1_bus.rdata : m0_bus.rdata) !== d) begin errors++; $display("FAIL alt_rdata[%0d] got %0h want %0h", i, exp_owner ? m1_bus.rdata : m0_bus.rdata, d); end
      tick();
      checks++; if (s_bus.valid !== 1'b0) begin errors++; $display("FAIL alt_done_gap[%0d] got %0h want 0", i, s_bus.valid); end
    end
    m0_bus.valid = 1'b0;
    m1_bus.valid = 1'b0;
    tick();
  endtask

  task automatic test_write_m1();
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h20; m1_bus.wdata = 32'hA5A5A5A5; m1_bus.wstrb = 4'b0011;
    tick();
    checks++; if ({s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb} !== {1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011}) begin errors++; $display("FAIL wr_capture got %0h/%0h/%0h/%0h want 1/20/a5a5a5a5/3", s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL wr_owner got %0h want 1", owner); end
    m1_bus.addr = 32'hFFFF0000; m1_bus.wdata = 32'h0; m1_bus.wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb} !== {1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011}) begin errors++; $display("FAIL wr_stable[%0d] got %0h/%0h/%0h/%0h want 1/20/a5a5a5a5/3", i, s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb); end
    end
    slave_respond(0, 32'h0);
    checks++; if ({m1_bus.ready, m0_bus.ready, owner} !== 3'b101) begin errors++; $display("FAIL wr_ready got %b want 101", {m1_bus.ready, m0_bus.ready, owner}); end
    m1_bus.valid = 1'b0;
    tick();
    checks++; if (m1_bus.ready !== 1'b0) begin errors++; $display("FAIL wr_pulse_len got %0h want 0", m1_bus.ready); end
    tick();
  endtask

  task automatic test_timeout();
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h300; m0_bus.wstrb = 4'h0;
    tick(); // first BUSY cycle
    repeat (15) tick(); // sixteenth BUSY cycle
    checks++; if ({s_bus.valid, m0_bus.ready} !== 2'b10) begin errors++; $display("FAIL to_before got %b want 10", {s_bus.valid, m0_bus.ready}); end
    tick();
    checks++; if ({s_bus.valid, m0_bus.ready} !== 2'b01) begin errors++; $display("FAIL to_expire got %b want 01", {s_bus.valid, m0_bus.ready}); end
    checks++; if (m0_bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rdata got %0h want deadbeef", m0_bus.rdata); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_set got %0h want 1", err_timeout); end
    m0_bus.valid = 1'b0;
    tick();
    checks++; if ({m0_bus.ready, err_timeout} !== 2'b01) begin errors++; $display("FAIL to_after got %b want 01", {m0_bus.ready, err_timeout}); end
    repeat (5) tick();
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err_sticky got %0h want 1", err_timeout); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_err_clr got %0h want 0", err_timeout); end
    // Second expiry with clear held: the set must win on the expiry edge.
    m0_bus.valid = 1'b1; err_clr = 1'b1;
    tick();
    repeat (15) tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr_held got %0h want 0", err_timeout); end
    tick();
    checks++; if ({err_timeout, m0_bus.ready} !== 2'b11) begin errors++; $display("FAIL to_set_wins got %b want 11", {err_timeout, m0_bus.ready}); end
    err_clr = 1'b0; m0_bus.valid = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_busy();
    bit ok;
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h340;
    tick();
    tick();
    checks++; if ({busy, s_bus.valid} !== 2'b11) begin errors++; $display("FAIL rb_busy got %b want 11", {busy, s_bus.valid}); end
    nrst = 1'b0;
    #1;
    checks++; if ({s_bus.valid, busy, m0_bus.ready, m1_bus.ready} !== 4'b0000) begin errors++; $display("FAIL rb_async got %b want 0000", {s_bus.valid, busy, m0_bus.ready, m1_bus.ready}); end
    checks++; if (m0_bus.rdata !== 32'h0) begin errors++; $display("FAIL rb_rdata got %0h want 0", m0_bus.rdata); end
    m0_bus.valid = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    tick();
    checks++; if (m0_bus.ready !== 1'b0) begin errors++; $display("FAIL rb_no_pulse got %0h want 0", m0_bus.ready); end
    // Both request: m0 must win again because prio is back to 0.
    m0_bus.valid = 1'b1; m0_bus.addr = 32'h400;
    m1_bus.valid = 1'b1; m1_bus.addr = 32'h500; m1_bus.wstrb = 4'h0;
    wait_svalid(ok);
    checks++; if (!ok || owner !== 1'b0) begin errors++; $display("FAIL rb_prio got ok=%0d owner=%0h want ok=1 owner=0", ok, owner); end
    slave_respond(2, 32'h0000C0DE);
    m0_bus.valid = 1'b0;
    tick();
    wait_svalid(ok);
    checks++; if (!ok || owner !== 1'b1 || s_bus.addr !== 32'h500) begin errors++; $display("FAIL rb_m1_grant got ok=%0d owner=%0h addr=%0h want 1/1/500", ok, owner, s_bus.addr); end
    slave_respond(1, 32'h5555AAAA);
    checks++; if ({m1_bus.ready, m1_bus.rdata} !== {1'b1, 32'h5555AAAA}) begin errors++; $display("FAIL rb_m1_resp got %0h/%0h want 1/5555aaaa", m1_bus.ready, m1_bus.rdata); end
    m1_bus.valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_random();
    bit          ok;
    logic        pv[2];
    logic [31:0] pa[2];
    logic [31:0] pd[2];
    logic [3:0]  ps[2];
    logic        prio_m;
    int          g;
    int          lat;
    logic [31:0] rd;
    do_reset();
    prio_m = 1'b0;
    for (int m = 0; m < 2; m++) begin pv[m] = 1'b0; pa[m] = '0; pd[m] = '0; ps[m] = '0; end
    for (int it = 0; it < 24; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pv[m] && $urandom_range(0, 9) < 6) begin
          pv[m] = 1'b1; pa[m] = $urandom & 32'hFFFFFFFC; pd[m] = $urandom; ps[m] = 4'($urandom_range(0, 15));
        end
      end
      if (!pv[0] && !pv[1]) begin
        pv[it % 2] = 1'b1; pa[it % 2] = 32'h8000 + it * 4; pd[it % 2] = $urandom; ps[it % 2] = 4'hF;
      end
      m0_bus.valid = pv[0]; m0_bus.addr = pa[0]; m0_bus.wdata = pd[0]; m0_bus.wstrb = ps[0];
      m1_bus.valid = pv[1]; m1_bus.addr = pa[1]; m1_bus.wdata = pd[1]; m1_bus.wstrb = ps[1];
      g = (pv[0] && pv[1]) ? int'(prio_m) : (pv[1] ? 1 : 0);
      wait_svalid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_grant_wait[%0d] got no s_valid want s_valid", it); end
      checks++; if (owner !== g[0]) begin errors++; $display("FAIL rnd_owner[%0d] got %0h want %0d", it, owner, g); end
      checks++; if ({s_bus.addr, s_bus.wdata, s_bus.wstrb} !== {pa[g], pd[g], ps[g]}) begin errors++; $display("FAIL rnd_req[%0d] got %0h/%0h/%0h want %0h/%0h/%0h", it, s_bus.addr, s_bus.wdata, s_bus.wstrb, pa[g], pd[g], ps[g]); end
      lat = $urandom_range(0, 8);
      rd = $urandom;
      slave_respond(lat, rd);
      checks++; if ({m1_bus.ready, m0_bus.ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", it, {m1_bus.ready, m0_bus.ready}, (g == 1) ? 2'b10 : 2'b01); end
      checks++; if (((g == 1) ? m1_bus.rdata : m0_bus.rdata) !== rd) begin errors++; $display("FAIL rnd_rdata[%0d] got %0h want %0h", it, (g == 1) ? m1_bus.rdata : m0_bus.rdata, rd); end
      pv[g] = 1'b0;
      if (g == 1) m1_bus.valid = 1'b0; else m0_bus.valid = 1'b0;
      prio_m = (g == 0);
      tick();
      checks++; if ({s_bus.valid, m1_bus.ready, m0_bus.ready} !== 3'b000) begin errors++; $display("FAIL rnd_gap[%0d] got %b want 000", it, {s_bus.valid, m1_bus.ready, m0_bus.ready}); end
    end
    // Drain any request still waiting so it is answered exactly once.
    for (int m = 0; m < 2; m++) begin
      if (pv[m]) begin
        wait_svalid(ok);
        checks++; if (!ok || owner !== m[0]) begin errors++; $display("FAIL rnd_drain[%0d] got ok=%0d owner=%0h want ok=1 owner=%0d", m, ok, owner, m); end
        slave_respond(1, 32'h600D0000 + m);
        if (m == 1) m1_bus.valid = 1'b0; else m0_bus.valid = 1'b0;
        pv[m] = 1'b0;
        tick();
      end
    end
    tick();
    checks++; if ({busy, s_bus.valid} !== 2'b00) begin errors++; $display("FAIL rnd_quiet got %b want 00", {busy, s_bus.valid}); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_m1();
    test_timeout();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
